dm_unit: RTL and testbench

- MEM-stage data memory, directly downstream of the MEM-stage decode.
- Consumes `MemWrite`, `DMin_Src` (store width) and `DMout_Src` (load width/extension) and performs the access against a word-organised RAM.
- Does byte/halfword store merge and load lane select with sign/zero extension.
- Flags misaligned or out-of-range accesses.
- After reset, zero-fills the whole array with a sequential clear engine and holds `busy` so the hazard unit stalls the pipeline.

---
 rtl/dm_unit.sv | 161 ++++++++++++++++
 tb/tb_dm_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_unit.sv
`default_nettype none
// ============================================================================
// Module   : dm_unit
// Purpose  : MEM-stage data memory. Word-organised RAM with byte/halfword
//            store merge, load lane select with sign/zero extension, and
//            detection of misaligned or out-of-range stores. After reset a
//            sequential engine zero-fills the array while busy is held high.
// Ports    : clk        - pipeline clock, rising edge
//            reset      - synchronous, active-high
//            pc         - PC of the MEM-stage instruction (trace only)
//            addr       - byte address from the ALU result
//            wdata      - store data (already forwarded)
//            MemWrite   - store request
//            DMin_Src   - store width, [1:0]: 0 word, 1 half, 2 byte, 3 word
//            DMout_Src  - load mode, [2:0]: 0 word, 1 lh, 2 lhu, 3 lb,
//                         4 lbu, 5-7 word
//            rdata      - extended load data (combinational)
//            busy       - clear in progress, pipeline must stall
//            align_err  - current store is misaligned or out of range
//            err_sticky - set by any suppressed store, cleared by reset
// Options  : DM_TRACE_EN - when defined, prints one line per committed or
//            suppressed store (simulation only).
// Revision : 1.0 - initial release
// ============================================================================
module dm_unit #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemWrite,
    input  logic [31:0] DMin_Src,
    input  logic [31:0] DMout_Src,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        align_err,
    output logic        err_sticky
);

    localparam int                   c_WORDS    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] c_LAST_IDX = '1;
    localparam logic [ADDR_BITS-1:0] c_IDX_ONE  = 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_clr_idx;
    logic                 r_err_sticky;
    logic [31:0]          r_mem [c_WORDS];

    logic [31:0]          w_offset;
    logic                 w_in_range;
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          w_cur;
    logic [1:0]           w_st_mode;
    logic [2:0]           w_ld_mode;
    logic                 w_misaligned;
    logic                 w_commit;
    logic [31:0]          w_merged;
    logic [15:0]          w_half;
    logic [7:0]           w_byte;
    logic                 w_unused;

    // BASE_ADDR is aligned to the array size, so the index bits of addr
    // equal those of the offset and the range test only needs the upper bits.
    assign w_offset   = addr - BASE_ADDR;
    assign w_in_range = (w_offset[31:ADDR_BITS+2] == '0);
    assign w_idx      = addr[ADDR_BITS+1:2];
    assign w_cur      = r_mem[w_idx];
    assign w_st_mode  = DMin_Src[1:0];
    assign w_ld_mode  = DMout_Src[2:0];

    assign w_unused = ^{DMin_Src[31:2], DMout_Src[31:3], pc, w_offset[ADDR_BITS+1:0]};

    always_comb begin
        case (w_st_mode)
            2'd1:    w_misaligned = addr[0];
            2'd2:    w_misaligned = 1'b0;
            default: w_misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    assign busy       = reset | (r_state == ST_CLEAR);
    assign align_err  = MemWrite & ~busy & (w_misaligned | ~w_in_range);
    assign w_commit   = MemWrite & ~busy & ~w_misaligned & w_in_range;
    assign err_sticky = r_err_sticky;

    // Store merge: unselected lanes keep the current word content.
    always_comb begin
        w_merged = w_cur;
        case (w_st_mode)
            2'd1: begin
                if (addr[1]) w_merged[31:16] = wdata[15:0];
                else         w_merged[15:0]  = wdata[15:0];
            end
            2'd2:    w_merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: w_merged = wdata;
        endcase
    end

    // Load lane select; low address bits pick the lane without any check.
    assign w_half = addr[1] ? w_cur[31:16] : w_cur[15:0];
    assign w_byte = w_cur[{addr[1:0], 3'b000} +: 8];

    always_comb begin
        rdata = 32'h0;
        if (!busy && w_in_range) begin
            case (w_ld_mode)
                3'd1:    rdata = {{16{w_half[15]}}, w_half};
                3'd2:    rdata = {16'h0, w_half};
                3'd3:    rdata = {{24{w_byte[7]}}, w_byte};
                3'd4:    rdata = {24'h0, w_byte};
                default: rdata = w_cur;
            endcase
        end
    end

    // Control: clear sequencer and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clr_idx    <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            if (align_err) r_err_sticky <= 1'b1;
            case (r_state)
                ST_CLEAR: begin
                    r_clr_idx <= r_clr_idx + c_IDX_ONE;
                    if (r_clr_idx == c_LAST_IDX) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Array write port, shared by the clear engine and committed stores.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_CLEAR) r_mem[r_clr_idx] <= '0;
            else if (w_commit)       r_mem[w_idx]     <= w_merged;
        end
    end

`ifdef DM_TRACE_EN
    always_ff @(posedge clk) begin
        if (w_commit)
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
        else if (align_err)
            $display("ERR %d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_merged);
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_dm_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_unit
// Purpose  : Self-checking bench for dm_unit (ADDR_BITS = 4). A behavioural
//            memory model predicts busy, align_err, err_sticky and rdata on
//            every cycle; directed steps pin the model with literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_unit;

    localparam int          AB    = 4;
    localparam int          NW    = 16;
    localparam bit [31:0]   BYTES = 32'd64;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, addr, wdata, DMin_Src, DMout_Src;
    logic        MemWrite;
    logic [31:0] rdata;
    logic        busy, align_err, err_sticky;

    always #5 clk = ~clk;

    dm_unit #(.ADDR_BITS(AB), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wdata(wdata),
        .MemWrite(MemWrite), .DMin_Src(DMin_Src), .DMout_Src(DMout_Src),
        .rdata(rdata), .busy(busy), .align_err(align_err),
        .err_sticky(err_sticky)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    bit [31:0] m_mem [NW];
    int        m_clear_left = 0;
    bit        m_sticky = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (reset === 1'b1) || (m_clear_left > 0);
    endfunction

    function automatic bit m_oor(bit [31:0] a);
        return (a - BASE) >= BYTES;
    endfunction

    function automatic bit m_mis(bit [31:0] a, bit [31:0] st);
        case (st % 4)
            1:       return (a % 2) != 0;
            2:       return 1'b0;
            default: return (a % 4) != 0;
        endcase
    endfunction

    function automatic bit m_aerr();
        return (MemWrite === 1'b1) && !m_busy() && (m_mis(addr, DMin_Src) || m_oor(addr));
    endfunction

    function automatic bit [31:0] m_merge(bit [31:0] old, bit [31:0] a, bit [31:0] d, bit [31:0] st);
        bit [31:0] mask;
        int        sh;
        case (st % 4)
            1: begin
                sh   = 16 * ((a / 2) % 2);
                mask = 32'hFFFF << sh;
                return (old & ~mask) | ((d % 65536) << sh);
            end
            2: begin
                sh   = 8 * (a % 4);
                mask = 32'hFF << sh;
                return (old & ~mask) | ((d % 256) << sh);
            end
            default: return d;
        endcase
    endfunction

    function automatic bit [31:0] m_load(bit [31:0] a, bit [31:0] mode);
        bit [31:0] w, h, b;
        if (m_busy() || m_oor(a)) return 32'h0;
        w = m_mem[(a - BASE) / 4];
        h = (w >> (16 * ((a / 2) % 2))) % 65536;
        b = (w >> (8 * (a % 4))) % 256;
        case (mode % 8)
            1:       return (h >= 32768) ? (h + 32'hFFFF0000) : h;
            2:       return h;
            3:       return (b >= 128) ? (b + 32'hFFFFFF00) : b;
            4:       return b;
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_clear_left <= NW;
            m_sticky     <= 1'b0;
            for (int i = 0; i < NW; i++) m_mem[i] <= 32'h0;
        end else if (m_clear_left > 0) begin
            m_clear_left <= m_clear_left - 1;
        end else if (MemWrite === 1'b1) begin
            if (m_aerr()) m_sticky <= 1'b1;
            else m_mem[(addr - BASE) / 4] <= m_merge(m_mem[(addr - BASE) / 4], addr, wdata, DMin_Src);
        end
    end

    // Compare process: outputs sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       {31'h0, busy},       {31'h0, m_busy()});
            check("align_err",  {31'h0, align_err},  {31'h0, m_aerr()});
            check("err_sticky", {31'h0, err_sticky}, {31'h0, m_sticky});
            check("rdata",      rdata,               m_load(addr, DMout_Src));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit we, input bit [31:0] a, input bit [31:0] d,
                          input bit [31:0] st, input bit [31:0] ld);
        MemWrite  = we;
        addr      = a;
        wdata     = d;
        DMin_Src  = st;
        DMout_Src = ld;
        pc        = pc + 32'd4;
    endtask

    // Counts busy cycles after reset deassert; a store is issued at cycle inject_at.
    task automatic count_busy(input int inject_at, output int cnt);
        bit done = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (k == inject_at) set_op(1'b1, 32'h0, 32'h1, 32'h0, 32'h0);
            else                set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (busy === 1'b1) cnt++;
            else done = 1'b1;
            tick();
        end
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    bit [31:0] ld_a [5] = '{32'hB, 32'hB, 32'hA, 32'hA, 32'h9};
    bit [31:0] ld_m [5] = '{32'd3, 32'd4, 32'd1, 32'd2, 32'd3};
    bit [31:0] ld_e [5] = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA5A5, 32'h0000A5A5, 32'h00000012};

    initial begin
        int cnt;
        reset = 1'b1; MemWrite = 1'b0; addr = '0; wdata = '0; pc = '0;
        DMin_Src = '0; DMout_Src = '0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Clear length, with a store issued late in the clear (must be ignored).
        count_busy(12, cnt);
        check("busy_len", cnt, 32'd16);
        for (int i = 0; i < NW; i++) begin
            set_op(1'b0, i * 4, 32'h0, 32'h0, 32'h0);
            @(negedge clk);
            check("clr_word", rdata, 32'h0);
            tick();
        end

        // Word store, read-during-write, read-back.
        set_op(1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 32'h0);
        @(negedge clk); check("rdw_old", rdata, 32'h0);
        tick();
        set_op(1'b0, 32'h8, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("lw8", rdata, 32'hDEADBEEF);
        tick();

        // Byte and halfword merge.
        set_op(1'b1, 32'h9, 32'h12, 32'h2, 32'h0); tick();
        set_op(1'b0, 32'h8, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("sb_merge", rdata, 32'hDEAD12EF);
        tick();
        set_op(1'b1, 32'hA, 32'hA5A5, 32'h1, 32'h0); tick();
        set_op(1'b0, 32'h8, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("sh_merge", rdata, 32'hA5A512EF);
        tick();

        // Extension.
        for (int i = 0; i < 5; i++) begin
            set_op(1'b0, ld_a[i], 32'h0, 32'h0, ld_m[i]);
            @(negedge clk); check("ld_ext", rdata, ld_e[i]);
            tick();
        end

        // Misaligned / out-of-range stores.
        set_op(1'b1, 32'h6, 32'h11111111, 32'h0, 32'h0);
        @(negedge clk);
        check("aerr_sw6", {31'h0, align_err}, 32'h1);
        check("sticky_pre", {31'h0, err_sticky}, 32'h0);
        tick();
        set_op(1'b0, 32'h4, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check("sticky_set", {31'h0, err_sticky}, 32'h1);
        check("sw6_nochg", rdata, 32'h0);
        tick();
        set_op(1'b1, 32'h3, 32'h2222, 32'h1, 32'h0);
        @(negedge clk); check("aerr_sh3", {31'h0, align_err}, 32'h1);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("sh3_nochg", rdata, 32'h0);
        tick();
        set_op(1'b1, 32'h40, 32'h33333333, 32'h0, 32'h0);
        @(negedge clk); check("aerr_oor", {31'h0, align_err}, 32'h1);
        tick();
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("oor_nochg", rdata, 32'h0);
        tick();
        set_op(1'b0, 32'h40, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("oor_load", rdata, 32'h0);
        tick();
        set_op(1'b0, 32'h8, 32'h0, 32'h0, 32'h0);
        @(negedge clk); check("w8_kept", rdata, 32'hA5A512EF);
        tick();

        // Randomized traffic checked by the model.
        for (int n = 0; n < 600; n++) begin
            bit [31:0] a;
            a = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 79);
            reset = ($urandom_range(0, 199) == 0);
            set_op($urandom_range(0, 1) == 1, a, $urandom, $urandom, $urandom);
            tick();
        end
        reset = 1'b0;
        set_op(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (20) tick();

        // Reset pulsed at clear cycle 7 restarts the clear.
        reset = 1'b1; tick();
        reset = 1'b0;
        repeat (7) tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        count_busy(-1, cnt);
        check("busy_restart", cnt, 32'd16);
        @(negedge clk);
        check("sticky_rst", {31'h0, err_sticky}, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
